// File: rtl/controller_led_tx_if.sv
// Write port from the game logic plus the serial LED link to the player boards.
interface controller_led_tx_if;
    logic       wr_en;
    logic [1:0] wr_player;
    logic [7:0] wr_data;
    logic       led_sclk;
    logic       led_sdata;
    logic       led_latch;
    logic       busy;

    modport master (
        output wr_en, wr_player, wr_data,
        input  led_sclk, led_sdata, led_latch, busy
    );

    modport slave (
        input  wr_en, wr_player, wr_data,
        output led_sclk, led_sdata, led_latch, busy
    );
endinterface

// File: rtl/controller_led_tx.sv
// Player LED feedback driver: four shadow bytes serialised MSB first (p4..p1)
// onto a daisy-chained shift-register link with sclk, data and latch.
module controller_led_tx #(
    parameter int DIV     = 25,
    parameter int REFRESH = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    controller_led_tx_if.slave   bus
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (REFRESH > 0) ? $clog2(REFRESH + 1) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [IW-1:0] REF_MAX  = IW'(REFRESH);
    localparam bit            REF_ON   = (REFRESH != 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SLOW  = 3'd2,
        SHIGH = 3'd3,
        LATCH = 3'd4
    } state_t;

    state_t        state_r;
    logic [7:0]    shadow_r [0:3];
    logic          dirty_r;
    logic [31:0]   shift_r;
    logic [4:0]    bit_cnt_r;
    logic [DW-1:0] div_cnt_r;
    logic [IW-1:0] idle_cnt_r;
    logic          sclk_r;
    logic          sdata_r;
    logic          latch_r;
    logic          busy_r;
    logic          refresh_due_s;

    // Automatic resend is due once the idle counter has saturated.
    always_comb begin
        refresh_due_s = 1'b0;
        if (REF_ON && (idle_cnt_r == REF_MAX)) begin
            refresh_due_s = 1'b1;
        end else begin
            refresh_due_s = 1'b0;
        end
    end

    // Shadow bytes accept writes at any time; the frame in flight uses its own snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                shadow_r[i] <= 8'h00;
            end
        end else if (bus.wr_en) begin
            shadow_r[bus.wr_player] <= bus.wr_data;
        end
    end

    // Frame sequencer with registered link outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            dirty_r    <= 1'b1;
            shift_r    <= 32'h0000_0000;
            bit_cnt_r  <= 5'd0;
            div_cnt_r  <= '0;
            idle_cnt_r <= '0;
            sclk_r     <= 1'b0;
            sdata_r    <= 1'b0;
            latch_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            if (bus.wr_en) begin
                dirty_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (dirty_r || refresh_due_s) begin
                        state_r    <= LOAD;
                        busy_r     <= 1'b1;
                        idle_cnt_r <= '0;
                    end else if (idle_cnt_r != REF_MAX) begin
                        idle_cnt_r <= idle_cnt_r + IW'(1);
                    end
                end
                LOAD: begin
                    // A write landing on this cycle misses the snapshot, so keep dirty for it.
                    dirty_r   <= bus.wr_en;
                    shift_r   <= {shadow_r[3], shadow_r[2], shadow_r[1], shadow_r[0]};
                    bit_cnt_r <= 5'd31;
                    div_cnt_r <= DIV_LAST;
                    sclk_r    <= 1'b0;
                    sdata_r   <= shadow_r[3][7];
                    state_r   <= SLOW;
                end
                SLOW: begin
                    if (div_cnt_r == '0) begin
                        state_r   <= SHIGH;
                        sclk_r    <= 1'b1;
                        div_cnt_r <= DIV_LAST;
                    end else begin
                        div_cnt_r <= div_cnt_r - DW'(1);
                    end
                end
                SHIGH: begin
                    if (div_cnt_r != '0) begin
                        div_cnt_r <= div_cnt_r - DW'(1);
                    end else if (bit_cnt_r == 5'd0) begin
                        state_r   <= LATCH;
                        sclk_r    <= 1'b0;
                        latch_r   <= 1'b1;
                        div_cnt_r <= DIV_LAST;
                    end else begin
                        state_r   <= SLOW;
                        sclk_r    <= 1'b0;
                        shift_r   <= {shift_r[30:0], 1'b0};
                        sdata_r   <= shift_r[30];
                        bit_cnt_r <= bit_cnt_r - 5'd1;
                        div_cnt_r <= DIV_LAST;
                    end
                end
                LATCH: begin
                    if (div_cnt_r == '0) begin
                        state_r    <= IDLE;
                        latch_r    <= 1'b0;
                        busy_r     <= 1'b0;
                        idle_cnt_r <= '0;
                    end else begin
                        div_cnt_r <= div_cnt_r - DW'(1);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    dirty_r    <= 1'b1;
                    sclk_r     <= 1'b0;
                    latch_r    <= 1'b0;
                    busy_r     <= 1'b0;
                    idle_cnt_r <= '0;
                end
            endcase
        end
    end

    assign bus.led_sclk  = sclk_r;
    assign bus.led_sdata = sdata_r;
    assign bus.led_latch = latch_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_controller_led_tx.sv
// Bench for controller_led_tx: captures serial frames on the link and scores them
// against expected frames queued when the writes are driven.
module tb_controller_led_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    controller_led_tx_if bus ();
    controller_led_tx_if bus2 ();

    controller_led_tx #(.DIV(2), .REFRESH(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    controller_led_tx #(.DIV(2), .REFRESH(100)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          nbits;
        int          lat;
    } frame_t;

    typedef struct {
        logic [1:0]  pa;
        logic [7:0]  da;
        logic [1:0]  pb;
        logic [7:0]  db;
        logic [31:0] exp;
    } vec_t;

    frame_t      rx_q[$];
    frame_t      rx2_q[$];
    logic [31:0] exp_q[$];
    int          gap_q[$];

    // Link monitor for the main DUT
    logic        p_sclk = 1'b0, p_sdata = 1'b0, p_latch = 1'b0, p_busy = 1'b0;
    int          cur_bits = 0, lat_len = 0, viol = 0;
    logic [31:0] cur_data = 32'h0;
    always @(negedge clk) begin
        frame_t f;
        if (bus.busy === 1'b1 && p_busy !== 1'b1) begin
            cur_bits = 0;
            cur_data = 32'h0;
        end
        if (bus.led_sclk === 1'b1 && p_sclk !== 1'b1) begin
            cur_data = {cur_data[30:0], bus.led_sdata};
            cur_bits++;
        end
        if (bus.led_sclk === 1'b1 && p_sclk === 1'b1 && bus.led_sdata !== p_sdata) viol++;
        if (bus.led_latch === 1'b1) begin
            lat_len++;
        end else if (p_latch === 1'b1) begin
            f.data = cur_data; f.nbits = cur_bits; f.lat = lat_len;
            rx_q.push_back(f);
            lat_len = 0;
        end
        p_sclk = bus.led_sclk; p_sdata = bus.led_sdata;
        p_latch = bus.led_latch; p_busy = bus.busy;
    end

    // Monitor for the refresh DUT: frames and IDLE-entry to LOAD spacing
    logic        q_sclk = 1'b0, q_latch = 1'b0, q_busy = 1'b0;
    int          cur2_bits = 0, last_fall = 0;
    bit          have_fall = 1'b0;
    logic [31:0] cur2_data = 32'h0;
    always @(negedge clk) begin
        frame_t f;
        if (bus2.busy === 1'b1 && q_busy !== 1'b1) begin
            cur2_bits = 0;
            cur2_data = 32'h0;
            if (have_fall) gap_q.push_back(cyc - last_fall);
        end
        if (bus2.busy === 1'b0 && q_busy === 1'b1) begin
            last_fall = cyc;
            have_fall = 1'b1;
        end
        if (bus2.led_sclk === 1'b1 && q_sclk !== 1'b1) begin
            cur2_data = {cur2_data[30:0], bus2.led_sdata};
            cur2_bits++;
        end
        if (bus2.led_latch === 1'b0 && q_latch === 1'b1) begin
            f.data = cur2_data; f.nbits = cur2_bits; f.lat = 0;
            rx2_q.push_back(f);
        end
        q_sclk = bus2.led_sclk; q_latch = bus2.led_latch; q_busy = bus2.busy;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] p, input logic [7:0] d);
        bus.wr_en = 1'b1; bus.wr_player = p; bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int max, input string nm);
        int n = 0;
        while (bus.busy !== lvl && n < max) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " wait busy"}, {31'd0, bus.busy}, {31'd0, lvl});
    endtask

    task automatic measure_gap(input string nm);
        int g = 1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) break;
            g++;
        end
        chk({nm, " idle gap"}, g, 1);
    endtask

    task automatic check_frames(input string nm);
        frame_t      f;
        logic [31:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rx_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL %s: missing frame, got none expected %h", nm, e);
            end else begin
                f = rx_q.pop_front();
                chk({nm, " data"}, f.data, e);
                chk({nm, " bits"}, f.nbits, 32);
                chk({nm, " latch width"}, f.lat, 2);
            end
        end
        chk({nm, " extra frames"}, rx_q.size(), 0);
    endtask

    vec_t vecs[5];

    initial begin
        int hi;
        int n;
        frame_t f;

        vecs[0] = '{pa: 2'd0, da: 8'hA5, pb: 2'd3, db: 8'h81, exp: 32'h8100_00A5};
        vecs[1] = '{pa: 2'd1, da: 8'h12, pb: 2'd2, db: 8'h34, exp: 32'h8134_12A5};
        vecs[2] = '{pa: 2'd3, da: 8'h00, pb: 2'd0, db: 8'h00, exp: 32'h0034_1200};
        vecs[3] = '{pa: 2'd2, da: 8'hFF, pb: 2'd2, db: 8'hC3, exp: 32'h00C3_1200};
        vecs[4] = '{pa: 2'd1, da: 8'h0F, pb: 2'd0, db: 8'h01, exp: 32'h00C3_0F01};

        bus.wr_en = 1'b0; bus.wr_player = 2'd0; bus.wr_data = 8'h00;
        bus2.wr_en = 1'b0; bus2.wr_player = 2'd0; bus2.wr_data = 8'h00;

        // Reset and the clearing frame
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst sclk", {31'd0, bus.led_sclk}, 32'd0);
        chk("rst sdata", {31'd0, bus.led_sdata}, 32'd0);
        chk("rst latch", {31'd0, bus.led_latch}, 32'd0);
        chk("rst busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        exp_q.push_back(32'h0000_0000);
        @(negedge clk);
        chk("busy rise after release", {31'd0, bus.busy}, 32'd1);
        hi = 1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) break;
            hi++;
        end
        chk("busy length", hi, 131);
        @(negedge clk);
        check_frames("clear frame");

        // Table of write pairs, each producing one frame
        for (int i = 0; i < 5; i++) begin
            wr(vecs[i].pa, vecs[i].da);
            wr(vecs[i].pb, vecs[i].db);
            exp_q.push_back(vecs[i].exp);
            wait_busy(1'b1, 20, "vec");
            wait_busy(1'b0, 400, "vec");
            @(negedge clk);
            check_frames($sformatf("vec%0d", i));
        end

        // Write during a frame goes into a back-to-back second frame
        wr(2'd0, 8'h5A);
        exp_q.push_back(32'h00C3_0F5A);
        exp_q.push_back(32'h00C3_FF5A);
        wait_busy(1'b1, 20, "midframe");
        repeat (40) @(negedge clk);
        wr(2'd1, 8'hFF);
        wait_busy(1'b0, 400, "midframe first");
        measure_gap("midframe");
        wait_busy(1'b0, 400, "midframe second");
        hi = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) hi++;
        end
        chk("no third frame", hi, 0);
        check_frames("midframe");

        // Write on the exact LOAD cycle
        wr(2'd3, 8'h11);
        exp_q.push_back(32'h11C3_FF5A);
        exp_q.push_back(32'h113C_FF5A);
        wait_busy(1'b1, 20, "load write");
        wr(2'd2, 8'h3C);
        wait_busy(1'b0, 400, "load write first");
        measure_gap("load write");
        wait_busy(1'b0, 400, "load write second");
        @(negedge clk);
        check_frames("load write");

        // Periodic refresh on the second instance
        n = gap_q.size();
        chk("refresh frame count", {31'd0, n >= 3}, 32'd1);
        while (gap_q.size() > 0) chk("refresh spacing", gap_q.pop_front(), 101);
        while (rx2_q.size() > 0) begin
            f = rx2_q.pop_front();
            chk("refresh data", f.data, 32'h0);
            chk("refresh bits", f.nbits, 32);
        end

        // Reset in the middle of a frame
        wr(2'd0, 8'h77);
        wait_busy(1'b1, 20, "midreset");
        n = 0;
        while (cur_bits < 17 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("midreset reached bit 17", {31'd0, cur_bits >= 17}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset sclk", {31'd0, bus.led_sclk}, 32'd0);
        chk("midreset latch", {31'd0, bus.led_latch}, 32'd0);
        chk("midreset busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        chk("partial not latched", rx_q.size(), 0);
        exp_q.push_back(32'h0000_0000);
        wait_busy(1'b1, 20, "midreset");
        wait_busy(1'b0, 400, "midreset");
        @(negedge clk);
        check_frames("after reset");

        chk("sdata stable while sclk high", viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
